uart_rx_deser: RTL



---
 rtl/uart_rx_deser.sv | 113 +++++++++++
 1 files changed

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 16x-oversampled 8N1/8E1/8O1 UART receiver with a small valid/ready FIFO.
// Samples are taken on the ticks that advance sc to OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
module uart_rx_deser #(
    parameter int    CLK_HZ     = 14745600,
    parameter int    BAUD       = 115200,
    parameter int    OVERSAMPLE = 16,
    parameter string PARITY     = "NONE",
    parameter int    FIFO_DEPTH = 4
) (
    input  logic       clk_sys,
    input  logic       rst_sys,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int M = OVERSAMPLE / 2;
    localparam bit PAR_EN = PARITY != "NONE";
    localparam bit PAR_ODD = PARITY == "ODD";

    typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;

    state_t state, state_n;
    logic rx_m, rxs, armed, s0, s1, perr;
    logic tick, dec, wrap, bit_v, push, ferr, push_ok, ovr, pop, full;
    logic [DW-1:0] dc;
    logic [SW-1:0] sc;
    logic [2:0] bc;
    logic [7:0] sh;
    logic [AW:0] wp, rp;
    logic [8:0] mem [FIFO_DEPTH];

    assign tick = dc == DW'(DIV - 1);
    assign dec = tick && sc == SW'(M);
    assign wrap = tick && sc == SW'(OVERSAMPLE - 1);
    assign bit_v = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign pop = rx_valid && rx_ready;
    assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign push_ok = push && (!full || pop);
    assign ovr = push && full && !pop;
    assign rx_valid = wp != rp;
    assign {rx_perr, rx_data} = mem[rp[AW-1:0]];
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        push = 1'b0;
        ferr = 1'b0;
        case (state)
            IDLE:    if (armed && !rxs) state_n = START;
            START:   if (dec && bit_v) state_n = IDLE; else if (wrap) state_n = DATA;
            DATA:    if (wrap && bc == 3'd7) state_n = PAR_EN ? PAR_BIT : STOP;
            PAR_BIT: if (wrap) state_n = STOP;
            STOP: begin
                if (dec) begin
                    state_n = IDLE;
                    push = bit_v;
                    ferr = !bit_v;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) state <= rst_sys ? IDLE : state_n;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            rx_m <= 1'b1;
            rxs <= 1'b1;
            armed <= 1'b0;
            dc <= '0;
            sc <= '0;
            bc <= '0;
            s0 <= 1'b0;
            s1 <= 1'b0;
            sh <= '0;
            perr <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            rx_m <= rx;
            rxs <= rx_m;
            // re-armed only by a high line seen while idle, so a break reports once
            armed <= state == IDLE && (armed || rxs);
            dc <= (state == IDLE || tick) ? '0 : dc + 1'b1;
            sc <= state == IDLE ? '0 : !tick ? sc : sc == SW'(OVERSAMPLE - 1) ? '0 : sc + 1'b1;
            if (tick && sc == SW'(M - 2)) s0 <= rxs;
            if (tick && sc == SW'(M - 1)) s1 <= rxs;
            if (state == DATA && dec) sh <= {bit_v, sh[7:1]};
            if (state == DATA && wrap) bc <= bc + 1'b1;
            if (state == PAR_BIT && dec) perr <= ^sh ^ bit_v ^ PAR_ODD;
            frame_err <= ferr;
            overrun <= ovr;
            if (push_ok) begin
                mem[wp[AW-1:0]] <= {perr, sh};
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    end
endmodule
